control_sequencer: RTL and testbench

Parametrised multicycle control sequencer, successor to the current fixed-latency control FSM. Sequences the 16-opcode ISA, and adds the following:
- opcode latching at fetch;
- a variable-latency memory handshake;
- an illegal-opcode trap;
- a memory-timeout fault state;
- a retired-instruction counter.

It sits between instruction memory/IR and the datapath, driving every datapath control strobe.

---
 rtl/control_sequencer_pkg.sv | 74 +++++++
 rtl/control_sequencer_if.sv | 24 ++
 rtl/control_sequencer_ctrl_decode.sv | 62 ++++++
 rtl/control_sequencer.sv | 99 +++++++++
 tb/tb_control_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes, ALU/Regsrc codes and
// the packed control word.
package control_sequencer_pkg;

  localparam int unsigned CTRL_W = 26;

  typedef enum logic [3:0] {
    StRst    = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StEx     = 4'd3,
    StMem    = 4'd4,
    StWb     = 4'd5,
    StBranch = 4'd6,
    StJump   = 4'd7,
    StTrap   = 4'd8,
    StFault  = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    OpLda, OpLdi, OpStr, OpBop, OpCal, OpBeq, OpBne, OpSft,
    OpCop, OpIll, OpSlt, OpRet, OpAdd, OpSub, OpAnd, OpOrr
  } opcode_e;

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOrr = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd3;
  localparam logic [3:0] AluSft = 4'd4;
  localparam logic [3:0] AluSlt = 4'd5;

  localparam logic [1:0] RegsrcImm = 2'd0;
  localparam logic [1:0] RegsrcMem = 2'd1;
  localparam logic [1:0] RegsrcAlu = 2'd2;
  localparam logic [1:0] RegsrcCop = 2'd3;

  // Field order is MSB first; bit positions follow directly from this declaration.
  typedef struct packed {
    logic       pc_src;
    logic       write_pc;
    logic       write_ra;
    logic       imm_rpc;
    logic       mem_src;
    logic       mem_w1;
    logic       mem_w2;
    logic       mem_r1;
    logic       mem_r2;
    logic       write_cr;
    logic [1:0] reg_src;
    logic       backup;
    logic       restore;
    logic       reg_w1;
    logic       reg_w2;
    logic       reg_r1;
    logic       reg_r2;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       cmp_eq;
    logic       cmp_ne;
    logic       reset_sig;
  } ctrl_t;

  function automatic logic [3:0] alu_op_of(opcode_e op);
    case (op)
      OpSft:   return AluSft;
      OpSlt:   return AluSlt;
      OpSub:   return AluSub;
      OpAnd:   return AluAnd;
      OpOrr:   return AluOrr;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the sequencer (master) and the memory/IR/datapath side (slave).
interface control_sequencer_if
  import control_sequencer_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
);
  logic [3:0]          instr_op;
  logic                mem_ready;
  logic [CTRL_W-1:0]   ctrl;
  logic                illegal;
  logic                fault;
  logic [RETIRE_W-1:0] retired;
  logic [3:0]          state;

  modport master (
    input  instr_op, mem_ready,
    output ctrl, illegal, fault, retired, state
  );

  modport slave (
    output instr_op, mem_ready,
    input  ctrl, illegal, fault, retired, state
  );
endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// Purely combinational map from (state, latched opcode, mem_ready) to the datapath control word.
module ctrl_decode
  import control_sequencer_pkg::*;
(
  input  state_e  state_i,
  input  opcode_e op_i,
  input  logic    mem_ready_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StRst: begin
        ctrl_o.write_pc  = 1'b1;
        ctrl_o.reset_sig = 1'b1;
      end
      StFetch: begin
        ctrl_o.mem_r1   = 1'b1;
        ctrl_o.mem_r2   = 1'b1;
        ctrl_o.write_pc = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.reg_r1 = 1'b1;
        ctrl_o.reg_r2 = 1'b1;
      end
      StEx: begin
        ctrl_o.alu_src = !(op_i inside {OpLda, OpStr, OpSft});
        ctrl_o.alu_op  = alu_op_of(op_i);
      end
      StMem: begin
        ctrl_o.mem_src = 1'b1;
        ctrl_o.mem_r2  = (op_i == OpLda);
        ctrl_o.mem_w2  = (op_i == OpStr);
      end
      StWb: begin
        case (op_i)
          OpLdi: begin ctrl_o.reg_src = RegsrcImm; ctrl_o.reg_w2 = 1'b1; end
          OpLda: begin ctrl_o.reg_src = RegsrcMem; ctrl_o.reg_w2 = 1'b1; end
          OpCop: begin ctrl_o.reg_src = RegsrcCop; ctrl_o.reg_w2 = 1'b1; end
          OpSlt: begin ctrl_o.write_cr = 1'b1; ctrl_o.reg_w1 = 1'b1; end
          default: begin ctrl_o.reg_src = RegsrcAlu; ctrl_o.reg_w2 = 1'b1; end
        endcase
      end
      StBranch: begin
        ctrl_o.cmp_eq = (op_i == OpBeq);
        ctrl_o.cmp_ne = (op_i == OpBne);
      end
      StJump: begin
        ctrl_o.write_pc = 1'b1;
        case (op_i)
          OpBop: ctrl_o.imm_rpc = 1'b1;
          OpCal: begin ctrl_o.imm_rpc = 1'b1; ctrl_o.write_ra = 1'b1; ctrl_o.backup = 1'b1; end
          OpRet: begin ctrl_o.pc_src = 1'b1; ctrl_o.write_ra = 1'b1; ctrl_o.restore = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: FSM, memory wait/timeout counter and retired-instruction counter.
// All state updates on the falling clock edge; reset is asynchronous and active-high.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned RETIRE_W = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  control_sequencer_if.master bus_io
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  opcode_e             op_q, op_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic                timeout_hit;
  ctrl_t               ctrl;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;  // clears whenever the wait is not continuing
    retire  = 1'b0;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch, StMem: begin
        if (bus_io.mem_ready) begin
          if (state_q == StFetch) begin
            op_d    = opcode_e'(bus_io.instr_op);
            state_d = StDecode;
          end else if (op_q == OpLda) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        case (op_q)
          OpLdi, OpCop:        state_d = StWb;
          OpBop, OpCal, OpRet: state_d = StJump;
          OpBeq, OpBne:        state_d = StBranch;
          OpIll:               state_d = StTrap;
          default:             state_d = StEx;
        endcase
      end
      StEx: state_d = (op_q inside {OpLda, OpStr}) ? StMem : StWb;
      StWb, StBranch, StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase
  end

  assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StRst;
      op_q      <= OpLda;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  ctrl_decode u_ctrl_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .mem_ready_i (bus_io.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus_io.ctrl    = ctrl;
  assign bus_io.illegal = (state_q == StTrap);
  assign bus_io.fault   = (state_q == StFault);
  assign bus_io.retired = retired_q;
  assign bus_io.state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: default instance (A) plus TIMEOUT=4 / RETIRE_W=2 (B).
module tb_control_sequencer;

  localparam int PCSRC = 25, WPC = 24, WRA = 23, IMRPC = 22, MEMSRC = 21, MEMW1 = 20;
  localparam int MEMW2 = 19, MEMR1 = 18, MEMR2 = 17, WCR = 16, REGSRC = 14, BACKUP = 13;
  localparam int RESTORE = 12, REGW1 = 11, REGW2 = 10, REGR1 = 9, REGR2 = 8, ALUSRC = 7;
  localparam int ALUOP = 3, CMPEQ = 2, CMPNE = 1, RSTSIG = 0;

  typedef logic [25:0] cw_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  control_sequencer_if #(.RETIRE_W(16)) bus_a ();
  control_sequencer_if #(.RETIRE_W(2))  bus_b ();

  control_sequencer #(.TIMEOUT(16), .RETIRE_W(16)) u_dut_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus_a)
  );

  control_sequencer #(.TIMEOUT(4), .RETIRE_W(2)) u_dut_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus_b)
  );

  function automatic cw_t b(int p);
    return cw_t'(1) << p;
  endfunction

  function automatic cw_t aluw(int v);
    return cw_t'(v) << ALUOP;
  endfunction

  function automatic cw_t rsw(int v);
    return cw_t'(v) << REGSRC;
  endfunction

  cw_t w_rst, w_fetch, w_dec;

  // Registers move on the falling edge; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.mem_ready = 1'b1; bus_a.instr_op = 4'd0;
    bus_b.mem_ready = 1'b1; bus_b.instr_op = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.mem_ready = 1'b1; bus_a.instr_op = 4'd12;
    bus_b.mem_ready = 1'b1; bus_b.instr_op = 4'd12;
    tick();
    tick();
    checks++; if (bus_a.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus_a.state); end
    checks++; if (bus_a.ctrl !== w_rst) begin errors++; $display("FAIL reset_ctrl: got %h want %h", bus_a.ctrl, w_rst); end
    checks++; if (bus_a.illegal !== 1'b0 || bus_a.fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", bus_a.illegal, bus_a.fault); end
    checks++; if (bus_a.retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", bus_a.retired); end
    checks++; if (bus_b.state !== 4'd0 || bus_b.retired !== 2'd0) begin errors++; $display("FAIL reset_b: got state %0d retired %0d want 0 0", bus_b.state, bus_b.retired); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.state !== 4'd0) begin errors++; $display("FAIL reset_hold: got %0d want 0", bus_a.state); end
    tick();
    checks++; if (bus_a.state !== 4'd1) begin errors++; $display("FAIL reset_to_fetch: got %0d want 1", bus_a.state); end
  endtask

  // All 16 opcodes back to back with mem_ready=1; expected path after DECODE per opcode.
  task automatic test_opcodes();
    int   n;
    int   exp_ret;
    logic [3:0] st[3];
    cw_t  cw[3];
    do_reset();
    exp_ret = 0;
    tick();
    for (int op = 0; op < 16; op++) begin
      n = 0;
      case (op)
        0: begin n = 3; st = '{3, 4, 5}; cw = '{aluw(2), b(MEMSRC) | b(MEMR2), rsw(1) | b(REGW2)}; end
        1: begin n = 1; st[0] = 5; cw[0] = rsw(0) | b(REGW2); end
        2: begin n = 2; st[0] = 3; cw[0] = aluw(2); st[1] = 4; cw[1] = b(MEMSRC) | b(MEMW2); end
        3: begin n = 1; st[0] = 7; cw[0] = b(WPC) | b(IMRPC); end
        4: begin n = 1; st[0] = 7; cw[0] = b(WPC) | b(IMRPC) | b(WRA) | b(BACKUP); end
        5: begin n = 1; st[0] = 6; cw[0] = b(CMPEQ); end
        6: begin n = 1; st[0] = 6; cw[0] = b(CMPNE); end
        7: begin n = 2; st[0] = 3; cw[0] = aluw(4); st[1] = 5; cw[1] = rsw(2) | b(REGW2); end
        8: begin n = 1; st[0] = 5; cw[0] = rsw(3) | b(REGW2); end
        9: begin n = 1; st[0] = 8; cw[0] = '0; end
        10: begin n = 2; st[0] = 3; cw[0] = b(ALUSRC) | aluw(5); st[1] = 5; cw[1] = b(WCR) | b(REGW1); end
        11: begin n = 1; st[0] = 7; cw[0] = b(PCSRC) | b(WPC) | b(WRA) | b(RESTORE); end
        12: begin n = 2; st[0] = 3; cw[0] = b(ALUSRC) | aluw(2); st[1] = 5; cw[1] = rsw(2) | b(REGW2); end
        13: begin n = 2; st[0] = 3; cw[0] = b(ALUSRC) | aluw(3); st[1] = 5; cw[1] = rsw(2) | b(REGW2); end
        14: begin n = 2; st[0] = 3; cw[0] = b(ALUSRC) | aluw(0); st[1] = 5; cw[1] = rsw(2) | b(REGW2); end
        default: begin n = 2; st[0] = 3; cw[0] = b(ALUSRC) | aluw(1); st[1] = 5; cw[1] = rsw(2) | b(REGW2); end
      endcase
      bus_a.instr_op = 4'(op);
      bus_a.mem_ready = 1'b1;
      checks++; if (bus_a.state !== 4'd1 || bus_a.ctrl !== w_fetch) begin errors++; $display("FAIL op%0d_fetch: got state %0d ctrl %h want 1 %h", op, bus_a.state, bus_a.ctrl, w_fetch); end
      tick();
      checks++; if (bus_a.state !== 4'd2 || bus_a.ctrl !== w_dec) begin errors++; $display("FAIL op%0d_decode: got state %0d ctrl %h want 2 %h", op, bus_a.state, bus_a.ctrl, w_dec); end
      bus_a.instr_op = ~4'(op);  // must be ignored after fetch
      for (int j = 0; j < n; j++) begin
        tick();
        checks++; if (bus_a.state !== st[j] || bus_a.ctrl !== cw[j]) begin errors++; $display("FAIL op%0d_step%0d: got state %0d ctrl %h want %0d %h", op, j, bus_a.state, bus_a.ctrl, st[j], cw[j]); end
        checks++; if (bus_a.illegal !== (st[j] == 4'd8)) begin errors++; $display("FAIL op%0d_illegal%0d: got %b want %b", op, j, bus_a.illegal, st[j] == 4'd8); end
      end
      tick();
      if (op != 9) exp_ret++;
      checks++; if (bus_a.state !== 4'd1 || bus_a.illegal !== 1'b0) begin errors++; $display("FAIL op%0d_back: got state %0d illegal %b want 1 0", op, bus_a.state, bus_a.illegal); end
      checks++; if (bus_a.retired !== 16'(exp_ret)) begin errors++; $display("FAIL op%0d_retired: got %0d want %0d", op, bus_a.retired, exp_ret); end
    end
  endtask

  task automatic test_lda_wait();
    time t0;
    do_reset();
    bus_a.instr_op = 4'd0;
    tick();
    t0 = $time;
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus_a.mem_ready = 1'b1;
      checks++; if (bus_a.state !== 4'd4 || bus_a.ctrl !== (b(MEMSRC) | b(MEMR2))) begin errors++; $display("FAIL lda_mem%0d: got state %0d ctrl %h want 4 %h", i, bus_a.state, bus_a.ctrl, b(MEMSRC) | b(MEMR2)); end
    end
    tick();
    checks++; if (bus_a.state !== 4'd5 || bus_a.ctrl !== (rsw(1) | b(REGW2))) begin errors++; $display("FAIL lda_wb: got state %0d ctrl %h want 5 %h", bus_a.state, bus_a.ctrl, rsw(1) | b(REGW2)); end
    tick();
    checks++; if (bus_a.state !== 4'd1 || ($time - t0) != 80) begin errors++; $display("FAIL lda_latency: got state %0d cycles %0d want 1 8", bus_a.state, ($time - t0) / 10); end
    checks++; if (bus_a.retired !== 16'd1) begin errors++; $display("FAIL lda_retired: got %0d want 1", bus_a.retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus_b.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_b.state !== 4'd1 || bus_b.fault !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got state %0d fault %b want 1 0", i, bus_b.state, bus_b.fault); end
      tick();
    end
    bus_b.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_b.state !== 4'd9 || bus_b.fault !== 1'b1 || bus_b.ctrl !== 26'd0) begin errors++; $display("FAIL to_fault%0d: got state %0d fault %b ctrl %h want 9 1 0", i, bus_b.state, bus_b.fault, bus_b.ctrl); end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (bus_b.state !== 4'd0 || bus_b.fault !== 1'b0) begin errors++; $display("FAIL to_clear: got state %0d fault %b want 0 0", bus_b.state, bus_b.fault); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    bus_b.mem_ready = 1'b0;
    bus_b.instr_op = 4'd1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    bus_b.mem_ready = 1'b1;  // ready arrives in the would-be timeout cycle
    checks++; if (bus_b.state !== 4'd1) begin errors++; $display("FAIL tb_edge_fetch: got state %0d want 1", bus_b.state); end
    tick();
    checks++; if (bus_b.state !== 4'd2 || bus_b.fault !== 1'b0) begin errors++; $display("FAIL tb_edge_decode: got state %0d fault %b want 2 0", bus_b.state, bus_b.fault); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    bus_a.instr_op = 4'd1;
    tick();
    tick();
    bus_a.instr_op = 4'd2;
    tick();
    tick();
    checks++; if (bus_a.retired !== 16'd1) begin errors++; $display("FAIL mid_pre_retired: got %0d want 1", bus_a.retired); end
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    tick();
    checks++; if (bus_a.state !== 4'd4 || bus_a.ctrl !== (b(MEMSRC) | b(MEMW2))) begin errors++; $display("FAIL mid_mem: got state %0d ctrl %h want 4 %h", bus_a.state, bus_a.ctrl, b(MEMSRC) | b(MEMW2)); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus_a.state !== 4'd0 || bus_a.ctrl !== w_rst) begin errors++; $display("FAIL mid_abort: got state %0d ctrl %h want 0 %h", bus_a.state, bus_a.ctrl, w_rst); end
    checks++; if (bus_a.retired !== 16'd0) begin errors++; $display("FAIL mid_retired: got %0d want 0", bus_a.retired); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_retire_wrap();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    do_reset();
    bus_b.instr_op = 4'd1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      checks++; if (bus_b.state !== 4'd5) begin errors++; $display("FAIL wrap_wb%0d: got state %0d want 5", k, bus_b.state); end
      tick();
      checks++; if (bus_b.retired !== 2'(exp_seq[k])) begin errors++; $display("FAIL wrap_retired%0d: got %0d want %0d", k, bus_b.retired, exp_seq[k]); end
    end
  endtask

  initial begin
    w_rst   = b(WPC) | b(RSTSIG);
    w_fetch = b(MEMR1) | b(MEMR2) | b(WPC);
    w_dec   = b(REGR1) | b(REGR2);
    bus_a.mem_ready = 1'b1; bus_a.instr_op = 4'd0;
    bus_b.mem_ready = 1'b1; bus_b.instr_op = 4'd0;
    test_reset();
    test_opcodes();
    test_lda_wait();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_mem();
    test_retire_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
